// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - multi-digit 7-segment scan driver with per-frame snapshot and dead-time
// Optional blinking digits are enabled by defining SSD_BLINK_EN.
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_BITS = 16,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              ssdOut,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("ssd_scan_controller: illegal parameter value");
    end

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   en_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic                    frame_tick_q;
    logic                    tick, snap, blank, lit;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign tick = &cnt_q;
    assign snap = tick && (idx_q == LAST_IDX);

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank = 1'b0;
    end else begin : g_blank
        localparam logic [REFRESH_BITS-1:0] BLANK_LIM = REFRESH_BITS'(BLANK_CYCLES);
        assign blank = (cnt_q < BLANK_LIM);
    end

`ifdef SSD_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] blink_q;
    logic [FC_W-1:0]       fcnt_q;
    logic                  phase_q;

    // Frame count advances on the same edge that raises frame_tick, so phase flips on a frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (snap) begin
            blink_q <= blink_mask;
            if (fcnt_q == FC_LAST) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        lit = en_q[idx_q] && !blank;
`ifdef SSD_BLINK_EN
        lit = lit && !(blink_q[idx_q] && phase_q);
`endif
        anode_d  = '1;
        seg_d    = 7'h7F;
        dp_out_d = 1'b1;
        if (lit) begin
            anode_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d    = seg7(data_q[4*int'(idx_q) +: 4]);
            dp_out_d = ~dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            en_q         <= '0;
            dp_q         <= '0;
            anode_q      <= '1;
            seg_q        <= 7'h7F;
            dp_out_q     <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= snap;
            if (snap) begin
                data_q <= digit_data;
                en_q   <= digit_en;
                dp_q   <= dp_in;
            end
        end
    end

    assign anode      = anode_q;
    assign ssdOut     = seg_q;
    assign dp         = dp_out_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb/tb_ssd_scan_controller.sv - directed self-checking bench for ssd_scan_controller
module tb_ssd_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [3:0]  anode;
    logic [6:0]  ssdOut;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [3:0] cap_an  [32];
    logic [6:0] cap_seg [32];
    logic       cap_dp  [32];
    logic       cap_ft  [32];
    logic [6:0] seg_tab [16];

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_BITS(3),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_data(digit_data),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
`ifdef SSD_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .anode     (anode),
        .ssdOut    (ssdOut),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    // Sample j of a captured frame: j=0 is the frame_tick cycle; outputs lag (cnt,idx) by one clk.
    function automatic logic [3:0] exp_an(input int j, input logic [3:0] en);
        int d = (j - 1) / 8;
        int c = (j - 1) % 8;
        if (c < 2 || !en[d]) return 4'hF;
        case (d)
            0: return 4'hE;
            1: return 4'hD;
            2: return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int j, input logic [3:0] en, input logic [15:0] data);
        int d = (j - 1) / 8;
        int c = (j - 1) % 8;
        if (c < 2 || !en[d]) return 7'h7F;
        return seg_tab[data[4*d +: 4]];
    endfunction

    function automatic logic exp_dp(input int j, input logic [3:0] en, input logic [3:0] dpv);
        int d = (j - 1) / 8;
        int c = (j - 1) % 8;
        if (c < 2 || !en[d]) return 1'b1;
        return ~dpv[d];
    endfunction

    task automatic wait_ft(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 64);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("FAIL frame_tick_timeout waited %0d clks, required a pulse", n);
        end
    endtask

    task automatic capture(input int chg_j, input logic [15:0] chg_data);
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            cap_an[j]  = anode;
            cap_seg[j] = ssdOut;
            cap_dp[j]  = dp;
            cap_ft[j]  = frame_tick;
            if (j == chg_j) digit_data = chg_data;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 4;
            if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode cyc%0d got %h want f", i, anode); end
            if (ssdOut !== 7'h7F) begin errors++; $display("FAIL reset_seg cyc%0d got %h want 7f", i, ssdOut); end
            if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp cyc%0d got %b want 1", i, dp); end
            if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft cyc%0d got %b want 0", i, frame_tick); end
        end
    endtask

    task automatic test_first_frame();
        int n;
        digit_data = 16'h3A07;
        digit_en   = 4'hF;
        dp_in      = 4'h0;
        reset      = 1'b0;
        wait_ft(n);
        checks++;
        if (n !== 32) begin errors++; $display("FAIL first_ft_latency got %0d want 32", n); end
        capture(-1, 16'h0);
        for (int j = 1; j < 32; j++) begin
            checks += 4;
            if (cap_an[j] !== exp_an(j, 4'hF)) begin errors++; $display("FAIL first_anode j%0d got %h want %h", j, cap_an[j], exp_an(j, 4'hF)); end
            if (cap_seg[j] !== exp_seg(j, 4'hF, 16'h3A07)) begin errors++; $display("FAIL first_seg j%0d got %b want %b", j, cap_seg[j], exp_seg(j, 4'hF, 16'h3A07)); end
            if (cap_dp[j] !== 1'b1) begin errors++; $display("FAIL first_dp j%0d got %b want 1", j, cap_dp[j]); end
            if (cap_ft[j] !== 1'b0) begin errors++; $display("FAIL first_ft_width j%0d got %b want 0", j, cap_ft[j]); end
        end
    endtask

    task automatic test_enable_mask();
        int n;
        digit_en = 4'b0101;
        dp_in    = 4'b0100;
        wait_ft(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL en_ft_period got %0d want 1 (32 clk period)", n); end
        capture(-1, 16'h0);
        for (int j = 1; j < 32; j++) begin
            checks += 3;
            if (cap_an[j] !== exp_an(j, 4'b0101)) begin errors++; $display("FAIL en_anode j%0d got %h want %h", j, cap_an[j], exp_an(j, 4'b0101)); end
            if (cap_seg[j] !== exp_seg(j, 4'b0101, 16'h3A07)) begin errors++; $display("FAIL en_seg j%0d got %b want %b", j, cap_seg[j], exp_seg(j, 4'b0101, 16'h3A07)); end
            if (cap_dp[j] !== exp_dp(j, 4'b0101, 4'b0100)) begin errors++; $display("FAIL en_dp j%0d got %b want %b", j, cap_dp[j], exp_dp(j, 4'b0101, 4'b0100)); end
        end
    endtask

    task automatic test_mid_frame_change();
        int n;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        wait_ft(n);
        capture(10, 16'hFFFF);
        for (int j = 1; j < 32; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg(j, 4'hF, 16'h3A07)) begin errors++; $display("FAIL tear_old_seg j%0d got %b want %b", j, cap_seg[j], exp_seg(j, 4'hF, 16'h3A07)); end
        end
        wait_ft(n);
        capture(-1, 16'h0);
        for (int j = 1; j < 32; j++) begin
            checks += 2;
            if (cap_seg[j] !== exp_seg(j, 4'hF, 16'hFFFF)) begin errors++; $display("FAIL tear_new_seg j%0d got %b want %b", j, cap_seg[j], exp_seg(j, 4'hF, 16'hFFFF)); end
            if (cap_an[j] !== exp_an(j, 4'hF)) begin errors++; $display("FAIL tear_new_anode j%0d got %h want %h", j, cap_an[j], exp_an(j, 4'hF)); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_ft(n);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (anode !== 4'hF) begin errors++; $display("FAIL midrst_anode got %h want f", anode); end
        if (ssdOut !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h want 7f", ssdOut); end
        if (dp !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b want 1", dp); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_ft got %b want 0", frame_tick); end
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            checks++;
            if (anode !== 4'hF) begin errors++; $display("FAIL midrst_dark n%0d got %h want f", n, anode); end
        end while (!frame_tick && n < 64);
        checks++;
        if (n !== 32) begin errors++; $display("FAIL midrst_ft_latency got %0d want 32", n); end
        capture(-1, 16'h0);
        for (int j = 1; j < 32; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg(j, 4'hF, 16'hFFFF)) begin errors++; $display("FAIL midrst_resume_seg j%0d got %b want %b", j, cap_seg[j], exp_seg(j, 4'hF, 16'hFFFF)); end
        end
    endtask

`ifdef SSD_BLINK_EN
    task automatic test_blink();
        int n;
        logic [3:0] want0;
        digit_data = 16'h3A07;
        digit_en   = 4'hF;
        blink_mask = 4'b0001;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ft(n);
        for (int f = 1; f <= 6; f++) begin
            capture(-1, 16'h0);
            want0 = (f == 1 || f == 4 || f == 5) ? 4'hE : 4'hF;
            checks += 2;
            if (cap_an[4] !== want0) begin errors++; $display("FAIL blink_d0 frame%0d got %h want %h", f, cap_an[4], want0); end
            if (cap_an[12] !== 4'hD) begin errors++; $display("FAIL blink_d1 frame%0d got %h want d", f, cap_an[12]); end
            wait_ft(n);
            checks++;
            if (n !== 1) begin errors++; $display("FAIL blink_ft_period frame%0d got %0d want 1", f, n); end
        end
    endtask
`endif

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        reset      = 1'b1;
        digit_data = 16'h0;
        digit_en   = 4'h0;
        dp_in      = 4'h0;
        blink_mask = 4'h0;
        test_reset();
        test_first_frame();
        test_enable_mask();
        test_mid_frame_change();
        test_reset_mid();
`ifdef SSD_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
